in_port_fifo: RTL and testbench

- Input-port stage that sits directly upstream of the datapath's InPort bus source.
- An external device delivers 32-bit words with a Strobe; the block queues them in a small FIFO and presents the oldest word on BusMuxIn_InPort for the "in" instruction.
- When the control unit finishes an InPortout bus transfer, that word is consumed. Status flags let software or the bench detect overflow and underflow.

---
 rtl/in_port_fifo.sv | 110 +++++++++++
 tb/tb_in_port_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/in_port_fifo.sv
// in_port_fifo: queues words from an external device and presents the oldest
// one to the datapath's InPort bus source. A Strobe rising edge pushes one word.
// The falling edge of InPortout pops the word that the bus transfer just read.
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Strobe,
  input  logic [WIDTH-1:0] ExtData,
  input  logic             InPortout,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] BusMuxIn_InPort,
  output logic             Empty,
  output logic             Full,
  output logic [CW-1:0]    Count,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_strobe_d;
  logic             r_inport_d;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Status decode plus edge detection and same-cycle push/pop arbitration.
  // A full FIFO still accepts a push when a pop frees a slot in that cycle.
  // An empty FIFO rejects a pop even if a push arrives in the same cycle.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == CW'(DEPTH));
    w_push_req = Strobe & ~r_strobe_d;
    w_pop_req  = r_inport_d & ~InPortout;
    w_pop_ok   = w_pop_req & ~w_empty;
    w_push_ok  = w_push_req & (~w_full | w_pop_ok);
  end

  // Delayed copies of Strobe and InPortout, used by the edge detectors.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_strobe_d <= 1'b0;
      r_inport_d <= 1'b0;
    end else begin
      r_strobe_d <= Strobe;
      r_inport_d <= InPortout;
    end
  end

  // Storage is written only on an accepted push. A pop leaves the entry untouched.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= ExtData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // The occupancy count moves by the net change of accepted pushes and pops.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // Sticky error flags. A set event in the same cycle beats FlagClr.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_req & ~w_push_ok) r_overflow <= 1'b1;
      else if (FlagClr)            r_overflow <= 1'b0;
      if (w_pop_req & w_empty)     r_underflow <= 1'b1;
      else if (FlagClr)            r_underflow <= 1'b0;
    end
  end

  // Outputs come only from registered state, so ExtData cannot glitch the bus.
  always_comb begin
    BusMuxIn_InPort = w_empty ? '0 : r_mem[r_rd_ptr];
    Empty           = w_empty;
    Full            = w_full;
    Count           = r_count;
    Overflow        = r_overflow;
    Underflow       = r_underflow;
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// tb_in_port_fifo: directed scenarios and random traffic for in_port_fifo.
// The expected behaviour comes from a queue-based reference model.
module tb_in_port_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          Clock = 1'b0;
  logic          Clear;
  logic          Strobe;
  logic [W-1:0]  ExtData;
  logic          InPortout;
  logic          FlagClr;
  logic [W-1:0]  BusMuxIn_InPort;
  logic          Empty;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          Underflow;

  in_port_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .Clock(Clock), .Clear(Clear), .Strobe(Strobe), .ExtData(ExtData),
    .InPortout(InPortout), .FlagClr(FlagClr), .BusMuxIn_InPort(BusMuxIn_InPort),
    .Empty(Empty), .Full(Full), .Count(Count), .Overflow(Overflow),
    .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of held words, previous input levels, sticky flags.
  logic [W-1:0] q [$];
  bit m_sd, m_id, m_ovf, m_unf;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sd = 0; m_id = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input bit s, input logic [W-1:0] d, input bit ip, input bit fc);
    bit push_req, pop_req, pop_ok, push_ok;
    push_req = s && !m_sd;
    pop_req  = m_id && !ip;
    pop_ok   = pop_req && (q.size() > 0);
    push_ok  = push_req && ((q.size() < D) || pop_ok);
    if (fc) begin m_ovf = 0; m_unf = 0; end
    if (push_req && !push_ok) m_ovf = 1;
    if (pop_req && q.size() == 0) m_unf = 1;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    m_sd = s;
    m_id = ip;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, W'(Count), W'(q.size()));
    check({tag, ".empty"}, W'(Empty), W'(q.size() == 0));
    check({tag, ".full"},  W'(Full),  W'(q.size() == D));
    check({tag, ".head"},  BusMuxIn_InPort, (q.size() > 0) ? q[0] : '0);
    check({tag, ".ovf"},   W'(Overflow),  W'(m_ovf));
    check({tag, ".unf"},   W'(Underflow), W'(m_unf));
  endtask

  // One clock: drive inputs, let the edge happen, step the model, compare.
  task automatic cycle(input string tag, input bit s, input logic [W-1:0] d,
                       input bit ip, input bit fc);
    Strobe = s; ExtData = d; InPortout = ip; FlagClr = fc;
    @(posedge Clock);
    model_step(s, d, ip, fc);
    #1;
    compare_all(tag);
  endtask

  task automatic push(input string tag, input logic [W-1:0] d);
    cycle(tag, 1'b1, d, 1'b0, 1'b0);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, '0, 1'b1, 1'b0);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    Clear = 1'b0; Strobe = 1'b0; ExtData = '0; InPortout = 1'b0; FlagClr = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check("rst.count", W'(Count), 0);
    check("rst.empty", W'(Empty), 1);
    check("rst.full",  W'(Full), 0);
    check("rst.head",  BusMuxIn_InPort, 0);
    check("rst.flags", W'({Overflow, Underflow}), 0);
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock); #1;

    // Basic push/pop with a multi-cycle bus read.
    push("tp1", 32'h11);
    push("tp1", 32'h22);
    check("tp1.count2", W'(Count), 2);
    check("tp1.head11", BusMuxIn_InPort, 32'h11);
    for (int i = 0; i < 3; i++) cycle("tp1.rd", 1'b0, '0, 1'b1, 1'b0);
    check("tp1.stable", BusMuxIn_InPort, 32'h11);
    cycle("tp1.fall", 1'b0, '0, 1'b0, 1'b0);
    check("tp1.head22", BusMuxIn_InPort, 32'h22);
    check("tp1.count1", W'(Count), 1);
    pop("tp1");
    check("tp1.empty", W'(Empty), 1);
    check("tp1.head0", BusMuxIn_InPort, 0);

    // A long Strobe gives exactly one push.
    for (int i = 0; i < 10; i++) cycle("tp2", 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    cycle("tp2", 1'b0, '0, 1'b0, 1'b0);
    check("tp2.count", W'(Count), 1);
    pop("tp2");

    // Overflow on a full FIFO, in-order drain across the pointer wrap.
    for (int i = 1; i <= 5; i++) push("tp3", W'(i));
    check("tp3.full",  W'(Full), 1);
    check("tp3.ovf",   W'(Overflow), 1);
    check("tp3.count", W'(Count), 4);
    check("tp3.head",  BusMuxIn_InPort, 1);
    for (int i = 1; i <= 4; i++) begin
      check("tp3.seq", BusMuxIn_InPort, W'(i));
      pop("tp3");
    end
    push("tp3", 32'h6);
    check("tp3.head6", BusMuxIn_InPort, 6);
    cycle("tp3.fclr", 1'b0, '0, 1'b0, 1'b1);
    pop("tp3");

    // Push and pop in the same cycle while full.
    for (int i = 1; i <= 4; i++) push("tp4", W'(32'h40 + i));
    cycle("tp4", 1'b0, '0, 1'b1, 1'b0);
    cycle("tp4.sim", 1'b1, 32'h99, 1'b0, 1'b0);
    check("tp4.count", W'(Count), 4);
    check("tp4.ovf",   W'(Overflow), 0);
    cycle("tp4", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop("tp4");
    check("tp4.last", BusMuxIn_InPort, 32'h99);
    pop("tp4");

    // Underflow, flag clear, then push and pop together on an empty FIFO.
    pop("tp5");
    check("tp5.unf",   W'(Underflow), 1);
    check("tp5.count", W'(Count), 0);
    cycle("tp5.fclr", 1'b0, '0, 1'b0, 1'b1);
    check("tp5.unfclr", W'(Underflow), 0);
    cycle("tp5", 1'b0, '0, 1'b1, 1'b0);
    cycle("tp5.sim", 1'b1, 32'h7, 1'b0, 1'b0);
    check("tp5.count1", W'(Count), 1);
    check("tp5.head7",  BusMuxIn_InPort, 7);
    check("tp5.unf2",   W'(Underflow), 1);
    cycle("tp5", 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    push("tp6", 32'hB1);
    push("tp6", 32'hB2);
    #2;
    Clear = 1'b0;
    #1;
    model_reset();
    check("tp6.count", W'(Count), 0);
    check("tp6.empty", W'(Empty), 1);
    check("tp6.head",  BusMuxIn_InPort, 0);
    check("tp6.flags", W'({Overflow, Underflow}), 0);
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock); #1;
    push("tp6", 32'hC3);
    check("tp6.after", BusMuxIn_InPort, 32'hC3);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(0, 2) == 0), $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
